// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux-select arbiter: FSM states,
// requester count, select width and the pointer value used at reset.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  // ptr is reset to the top index so the first scan starts at requester 0.
  localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Bundle between the arbiter and its eight requesters.
// Handshake: req[i] is a level request; requester i may use the muxed bit
// only while grant[i]=1 (valid=1 and sel=i). A requester keeps req[i] high
// for as long as it wants the mux and drops it to release ownership.
// state is a debug view of the arbiter FSM.
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             busy;
  arb_state_t       state;

  modport master (
    input  req,
    output grant,
    output sel,
    output valid,
    output busy,
    output state
  );

  modport slave (
    output req,
    input  grant,
    input  sel,
    input  valid,
    input  busy,
    input  state
  );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first set req bit scanning upward
// from ptr+1 and wrapping 7->0; ptr itself is checked last.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    idx  = ptr;
    cand = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the 8:1 bit-select mux select. Registered one-hot
// grant, one idle GAP cycle between owners so the muxed bit never changes
// under a grant holder.
// Optional feature macro: MUX_ARB_TIMEOUT_EN -- adds the hold counter and
// preempts an owner after MAX_HOLD cycles when someone else is waiting.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.master  bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
    $error("mux_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic             valid_q;
  logic             load;
  logic             preempt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;

  // Tenure counter: cleared on every new grant, saturates at MAX_HOLD-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (state_q == GRANT && cnt_q != HOLD_LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Only a waiting competitor can end an expired tenure.
  assign preempt = (cnt_q == HOLD_LAST) && ((bus.req & ~grant_q) != '0);
`else
  assign preempt = 1'b0;
`endif

  // Next-state: grant from IDLE/GAP when anyone requests, leave GRANT via GAP.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          load    = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || preempt) state_d = GAP;
      end
      GAP: begin
        if (pick_any) begin
          state_d = GRANT;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, select and pointer registers; sel holds through GAP/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      if (load) begin
        grant_q <= N_REQ'(1) << pick_idx;
        sel_q   <= pick_idx;
        valid_q <= 1'b1;
        ptr_q   <= pick_idx;
      end else if (state_d != GRANT) begin
        grant_q <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.state = state_q;

endmodule
